voice_allocator: RTL

//  Polyphonic note-event scheduler for the synth voice bank. Accepts note-on/off

---
 rtl/voice_allocator.sv | 185 ++++++++++++++++++
 1 files changed

// File: rtl/voice_allocator.sv
// rtl/voice_allocator.sv - polyphonic note-event scheduler driving NUM_VOICES oscillator voices
//
// Ports:
//   clk           system clock
//   rst           asynchronous active-low reset
//   note_valid    event present
//   note_ready    block can accept an event (IDLE and out of reset)
//   note_on       1 = note-on, 0 = note-off
//   note_id       note identifier (MIDI note number)
//   note_freq     oscillator frequency word for note-on
//   voice_freq    voice v frequency at [20*v +: 20]
//   voice_gate    voice v sounding
//   voice_retrig  one-cycle phase-reset pulse per voice (one-hot or zero)
//   steal         one-cycle pulse: last note-on took over a gated voice
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int ID_W       = 7
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     note_valid,
    output logic                     note_ready,
    input  logic                     note_on,
    input  logic [ID_W-1:0]          note_id,
    input  logic [19:0]              note_freq,
    output logic [20*NUM_VOICES-1:0] voice_freq,
    output logic [NUM_VOICES-1:0]    voice_gate,
    output logic [NUM_VOICES-1:0]    voice_retrig,
    output logic                     steal
);

    localparam int VW = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOOKUP = 2'd1,
        UPDATE = 2'd2
    } state_t;

    state_t state_q, state_d;

    // Latched event
    logic            ev_on;
    logic [ID_W-1:0] ev_id;
    logic [19:0]     ev_freq;

    // Per-voice state; rank 0 = most recently allocated, NUM_VOICES-1 = oldest
    logic [19:0]     freq_q [NUM_VOICES];
    logic [ID_W-1:0] id_q   [NUM_VOICES];
    logic [VW-1:0]   rank_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] gate_q;
    logic [NUM_VOICES-1:0] retrig_q;
    logic                  steal_q;

    // Lookup results: combinational search, registered in LOOKUP
    logic          match_hit_c, free_hit_c;
    logic [VW-1:0] match_idx_c, free_idx_c, oldest_idx_c;
    logic          lk_match_hit, lk_free_hit;
    logic [VW-1:0] lk_match_idx, lk_free_idx, lk_oldest_idx;
    logic [VW-1:0] tgt;
    logic          accept;

    // Holding rst low forces ready low even though the state register already reads IDLE
    assign note_ready = (state_q == IDLE) && rst;
    assign accept     = note_valid && note_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = LOOKUP;
            LOOKUP:  state_d = UPDATE;
            UPDATE:  state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Scan high to low so the lowest matching index wins
    always_comb begin
        match_hit_c  = 1'b0;
        match_idx_c  = '0;
        free_hit_c   = 1'b0;
        free_idx_c   = '0;
        oldest_idx_c = '0;
        for (int v = NUM_VOICES - 1; v >= 0; v--) begin
            if (gate_q[v] && (id_q[v] == ev_id)) begin
                match_hit_c = 1'b1;
                match_idx_c = VW'(v);
            end
            if (!gate_q[v]) begin
                free_hit_c = 1'b1;
                free_idx_c = VW'(v);
            end
            if (rank_q[v] == VW'(NUM_VOICES - 1)) begin
                oldest_idx_c = VW'(v);
            end
        end
    end

    always_comb begin
        tgt = lk_oldest_idx;
        if (lk_match_hit) begin
            tgt = lk_match_idx;
        end else if (lk_free_hit) begin
            tgt = lk_free_idx;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ev_on         <= 1'b0;
            ev_id         <= '0;
            ev_freq       <= '0;
            lk_match_hit  <= 1'b0;
            lk_match_idx  <= '0;
            lk_free_hit   <= 1'b0;
            lk_free_idx   <= '0;
            lk_oldest_idx <= '0;
            gate_q        <= '0;
            retrig_q      <= '0;
            steal_q       <= 1'b0;
            for (int v = 0; v < NUM_VOICES; v++) begin
                freq_q[v] <= '0;
                id_q[v]   <= '0;
                rank_q[v] <= VW'(v);
            end
        end else begin
            // Pulses live for exactly one cycle
            retrig_q <= '0;
            steal_q  <= 1'b0;

            if (accept) begin
                ev_on   <= note_on;
                ev_id   <= note_id;
                ev_freq <= note_freq;
            end

            if (state_q == LOOKUP) begin
                lk_match_hit  <= match_hit_c;
                lk_match_idx  <= match_idx_c;
                lk_free_hit   <= free_hit_c;
                lk_free_idx   <= free_idx_c;
                lk_oldest_idx <= oldest_idx_c;
            end

            if (state_q == UPDATE) begin
                if (ev_on) begin
                    // A zero frequency word is a no-op note-on
                    if (ev_freq != '0) begin
                        freq_q[tgt]   <= ev_freq;
                        id_q[tgt]     <= ev_id;
                        gate_q[tgt]   <= 1'b1;
                        retrig_q[tgt] <= 1'b1;
                        steal_q       <= !lk_match_hit && !lk_free_hit;
                        // LRU: voices younger than the target age by one, target becomes newest
                        for (int v = 0; v < NUM_VOICES; v++) begin
                            if (rank_q[v] < rank_q[tgt]) begin
                                rank_q[v] <= rank_q[v] + 1'b1;
                            end
                        end
                        rank_q[tgt] <= '0;
                    end
                end else if (lk_match_hit) begin
                    gate_q[lk_match_idx] <= 1'b0;
                end
            end
        end
    end

    for (genvar g = 0; g < NUM_VOICES; g++) begin : g_freq
        assign voice_freq[20*g +: 20] = freq_q[g];
    end

    assign voice_gate   = gate_q;
    assign voice_retrig = retrig_q;
    assign steal        = steal_q;

endmodule
